// File: rtl/sakebi_ipv4_rx.sv
// ============================================================================
// sakebi_ipv4_rx : IPv4 header parser/filter with a registered payload slice.
// Rev 1.0
// ============================================================================
`default_nettype none

module sakebi_ipv4_rx #(
    parameter int DATA_WIDTH    = 8,
    parameter int IP_ADDR_WIDTH = 32
) (
    input  logic                     i_axis_ACLK,
    input  logic                     i_axis_ARESETn,
    input  logic                     i_axis_TVALID,
    output logic                     o_axis_TREADY,
    input  logic [DATA_WIDTH-1:0]    i_axis_TDATA,
    output logic                     o_axis_TVALID,
    input  logic                     i_axis_TREADY,
    output logic [DATA_WIDTH-1:0]    o_axis_TDATA,
    output logic [IP_ADDR_WIDTH-1:0] o_src_ip_addr,
    output logic [IP_ADDR_WIDTH-1:0] o_dst_ip_addr,
    output logic [7:0]               o_protocol,
    output logic [15:0]              o_total_length,
    output logic                     o_hdr_valid,
    output logic                     o_hdr_error,
    input  logic                     i_specify_ip_en,
    input  logic [IP_ADDR_WIDTH-1:0] i_ip_addr,
    input  logic                     i_specify_protocol_en,
    input  logic [7:0]               i_protocol
);

    typedef enum logic [1:0] {
        ST_HDR     = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DROP    = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [5:0]               cnt_q, cnt_d;
    logic [15:0]              rem_q, rem_d;
    logic [16:0]              acc_q, acc_d;
    logic [DATA_WIDTH-1:0]    hi_q, hi_d;
    logic [3:0]               ihl_q, ihl_d;
    logic [15:0]              tlen_q, tlen_d;
    logic [7:0]               proto_q, proto_d;
    logic [IP_ADDR_WIDTH-1:0] src_q, src_d;
    logic [IP_ADDR_WIDTH-1:0] dst_q, dst_d;
    logic                     out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
    logic [IP_ADDR_WIDTH-1:0] src_out_q, src_out_d;
    logic [IP_ADDR_WIDTH-1:0] dst_out_q, dst_out_d;
    logic [7:0]               proto_out_q, proto_out_d;
    logic [15:0]              tlen_out_q, tlen_out_d;
    logic                     hdr_valid_q, hdr_valid_d;
    logic                     hdr_error_q, hdr_error_d;

    logic        w_xfer;
    logic [5:0]  w_hdr_len;
    logic        w_last_hdr;
    logic [15:0] w_word;
    logic [16:0] w_acc_sum;
    logic [16:0] w_fold17;
    logic [15:0] w_fold;

    assign o_axis_TREADY = i_axis_ARESETn &&
                           ((state_q != ST_PAYLOAD) || !out_valid_q || i_axis_TREADY);
    assign w_xfer        = i_axis_TVALID && o_axis_TREADY;

    assign w_hdr_len  = {ihl_q, 2'b00};
    assign w_last_hdr = (cnt_q != 6'd0) && (cnt_q == w_hdr_len - 6'd1);

    // One's-complement running sum; the final fold absorbs the last carry twice.
    assign w_word    = {hi_q, i_axis_TDATA};
    assign w_acc_sum = {1'b0, acc_q[15:0]} + {1'b0, w_word} + {16'd0, acc_q[16]};
    assign w_fold17  = {1'b0, w_acc_sum[15:0]} + {16'd0, w_acc_sum[16]};
    assign w_fold    = w_fold17[15:0] + {15'd0, w_fold17[16]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        acc_d       = acc_q;
        hi_d        = hi_q;
        ihl_d       = ihl_q;
        tlen_d      = tlen_q;
        proto_d     = proto_q;
        src_d       = src_q;
        dst_d       = dst_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        src_out_d   = src_out_q;
        dst_out_d   = dst_out_q;
        proto_out_d = proto_out_q;
        tlen_out_d  = tlen_out_q;
        hdr_valid_d = 1'b0;
        hdr_error_d = 1'b0;

        if (out_valid_q && i_axis_TREADY) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_HDR: begin
                if (w_xfer) begin
                    cnt_d = cnt_q + 6'd1;
                    if (!cnt_q[0]) begin
                        hi_d = i_axis_TDATA;
                    end else begin
                        acc_d = w_acc_sum;
                    end
                    case (cnt_q)
                        6'd0: begin
                            ihl_d = i_axis_TDATA[3:0];
                            if (i_axis_TDATA[7:4] != 4'd4 || i_axis_TDATA[3:0] < 4'd5) begin
                                hdr_error_d = 1'b1;
                                state_d     = ST_DROP;
                            end
                        end
                        6'd2, 6'd3:
                            tlen_d = {tlen_q[7:0], i_axis_TDATA};
                        6'd9:
                            proto_d = i_axis_TDATA;
                        6'd12, 6'd13, 6'd14, 6'd15:
                            src_d = {src_q[IP_ADDR_WIDTH-DATA_WIDTH-1:0], i_axis_TDATA};
                        6'd16, 6'd17, 6'd18, 6'd19:
                            dst_d = {dst_q[IP_ADDR_WIDTH-DATA_WIDTH-1:0], i_axis_TDATA};
                        default: ;
                    endcase
                    // The last byte may complete dst IP, so checks use the _d values.
                    if (w_last_hdr) begin
                        cnt_d = 6'd0;
                        acc_d = 17'd0;
                        if (w_fold == 16'hFFFF &&
                            tlen_d >= {10'd0, w_hdr_len} &&
                            !(i_specify_ip_en && dst_d != i_ip_addr) &&
                            !(i_specify_protocol_en && proto_d != i_protocol)) begin
                            hdr_valid_d = 1'b1;
                            src_out_d   = src_d;
                            dst_out_d   = dst_d;
                            proto_out_d = proto_d;
                            tlen_out_d  = tlen_d;
                            rem_d       = tlen_d - {10'd0, w_hdr_len};
                            state_d     = (rem_d == 16'd0) ? ST_DROP : ST_PAYLOAD;
                        end else begin
                            hdr_error_d = 1'b1;
                            state_d     = ST_DROP;
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                if (w_xfer) begin
                    out_data_d  = i_axis_TDATA;
                    out_valid_d = 1'b1;
                    rem_d       = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (!i_axis_TVALID) begin
                    state_d = ST_HDR;
                    cnt_d   = 6'd0;
                    acc_d   = 17'd0;
                end
            end
            default: state_d = ST_HDR;
        endcase
    end

    always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
        if (!i_axis_ARESETn) begin
            state_q     <= ST_HDR;
            cnt_q       <= 6'd0;
            rem_q       <= 16'd0;
            acc_q       <= 17'd0;
            hi_q        <= '0;
            ihl_q       <= 4'd0;
            tlen_q      <= 16'd0;
            proto_q     <= 8'd0;
            src_q       <= '0;
            dst_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            src_out_q   <= '0;
            dst_out_q   <= '0;
            proto_out_q <= 8'd0;
            tlen_out_q  <= 16'd0;
            hdr_valid_q <= 1'b0;
            hdr_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            acc_q       <= acc_d;
            hi_q        <= hi_d;
            ihl_q       <= ihl_d;
            tlen_q      <= tlen_d;
            proto_q     <= proto_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            src_out_q   <= src_out_d;
            dst_out_q   <= dst_out_d;
            proto_out_q <= proto_out_d;
            tlen_out_q  <= tlen_out_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_error_q <= hdr_error_d;
        end
    end

    assign o_axis_TVALID  = out_valid_q;
    assign o_axis_TDATA   = out_data_q;
    assign o_src_ip_addr  = src_out_q;
    assign o_dst_ip_addr  = dst_out_q;
    assign o_protocol     = proto_out_q;
    assign o_total_length = tlen_out_q;
    assign o_hdr_valid    = hdr_valid_q;
    assign o_hdr_error    = hdr_error_q;

endmodule

`default_nettype wire

// File: tb/tb_sakebi_ipv4_rx.sv
// ============================================================================
// tb_sakebi_ipv4_rx : directed packets against a header/payload reference model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sakebi_ipv4_rx;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        ds_ready;
    logic [31:0] src_ip, dst_ip;
    logic [7:0]  proto;
    logic [15:0] tlen;
    logic        hdr_valid, hdr_error;
    logic        ip_en;
    logic [31:0] ip_addr;
    logic        pr_en;
    logic [7:0]  pr_val;

    int n_tests = 0;
    int n_fail  = 0;
    int rx_count = 0;
    int hv_cnt = 0;
    int he_cnt = 0;
    logic toggle_mode = 1'b0;
    logic [7:0] exp_q[$];
    logic [31:0] exp_src = 0, exp_dst = 0;
    logic [7:0]  exp_proto = 0;
    logic [15:0] exp_tlen = 0;

    sakebi_ipv4_rx #(.DATA_WIDTH(8), .IP_ADDR_WIDTH(32)) dut (
        .i_axis_ACLK          (clk),
        .i_axis_ARESETn       (rst_n),
        .i_axis_TVALID        (in_valid),
        .o_axis_TREADY        (in_ready),
        .i_axis_TDATA         (in_data),
        .o_axis_TVALID        (out_valid),
        .i_axis_TREADY        (ds_ready),
        .o_axis_TDATA         (out_data),
        .o_src_ip_addr        (src_ip),
        .o_dst_ip_addr        (dst_ip),
        .o_protocol           (proto),
        .o_total_length       (tlen),
        .o_hdr_valid          (hdr_valid),
        .o_hdr_error          (hdr_error),
        .i_specify_ip_en      (ip_en),
        .i_ip_addr            (ip_addr),
        .i_specify_protocol_en(pr_en),
        .i_protocol           (pr_val)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference model: header acceptance computed straight from the IPv4 rules.
    function automatic bit hdr_ok(input byte_q_t h);
        int unsigned sum;
        int hlen;
        logic [15:0] tl;
        logic [31:0] d;
        if (h[0][7:4] != 4'd4 || h[0][3:0] < 4'd5) return 1'b0;
        hlen = int'(h[0][3:0]) * 4;
        sum = 0;
        for (int i = 0; i < hlen; i += 2) sum += {h[i], h[i+1]};
        while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
        tl = {h[2], h[3]};
        d  = {h[16], h[17], h[18], h[19]};
        if (sum != 32'hFFFF) return 1'b0;
        if (int'(tl) < hlen) return 1'b0;
        if (ip_en && d != ip_addr) return 1'b0;
        if (pr_en && h[9] != pr_val) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        ds_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ds_ready = toggle_mode ? ~ds_ready : 1'b1;
        end
    end

    // Per-cycle compare of the output stream, stall stability and pulses.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
            end
            if (hdr_valid || hdr_error) check("pulse_exclusive", hdr_valid & hdr_error, 0);
            if (hdr_valid) hv_cnt++;
            if (hdr_error) he_cnt++;
            if (out_valid && ds_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL extra_byte: got %02h, required no byte", out_data);
                end else begin
                    check("payload_byte", out_data, exp_q.pop_front());
                end
                rx_count++;
            end
            prev_stall = out_valid && !ds_ready;
            prev_data  = out_data;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        logic acc;
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) return;
        end
        check("upstream_ready_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic byte_q_t build_stream(input byte_q_t h);
        byte_q_t s;
        s = h;
        for (int i = 1; i <= 8; i++) s.push_back(8'(i));
        for (int i = 0; i < 10; i++) s.push_back(8'hAA);
        return s;
    endfunction

    task automatic run_pkt(input string name, input byte_q_t h, input bit gap);
        byte_q_t s;
        bit ok;
        int hlen, rem;
        ok = hdr_ok(h);
        s  = build_stream(h);
        exp_q.delete();
        hv_cnt = 0;
        he_cnt = 0;
        rx_count = 0;
        if (ok) begin
            hlen = int'(h[0][3:0]) * 4;
            rem  = int'({h[2], h[3]}) - hlen;
            for (int i = 0; i < rem; i++) exp_q.push_back(s[hlen + i]);
            exp_src   = {h[12], h[13], h[14], h[15]};
            exp_dst   = {h[16], h[17], h[18], h[19]};
            exp_proto = h[9];
            exp_tlen  = {h[2], h[3]};
        end
        for (int i = 0; i < s.size(); i++) begin
            send_byte(s[i]);
            if (gap && i == 5) idle(2);
        end
        idle(8);
        check({name, "_hdr_valid_cnt"}, hv_cnt, ok ? 1 : 0);
        check({name, "_hdr_error_cnt"}, he_cnt, ok ? 0 : 1);
        check({name, "_undelivered"}, exp_q.size(), 0);
        check({name, "_src"}, src_ip, exp_src);
        check({name, "_dst"}, dst_ip, exp_dst);
        check({name, "_proto"}, proto, exp_proto);
        check({name, "_tlen"}, tlen, exp_tlen);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_tready"}, in_ready, 0);
        check({name, "_tvalid"}, out_valid, 0);
        check({name, "_tdata"}, out_data, 0);
        check({name, "_src"}, src_ip, 0);
        check({name, "_dst"}, dst_ip, 0);
        check({name, "_proto"}, proto, 0);
        check({name, "_tlen"}, tlen, 0);
        check({name, "_hv"}, hdr_valid, 0);
        check({name, "_he"}, hdr_error, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t good, h;
        byte_q_t s;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        ip_en    = 1'b0;
        ip_addr  = 32'h0;
        pr_en    = 1'b0;
        pr_val   = 8'h0;
        good = '{8'h45, 8'h00, 8'h00, 8'h1c, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h11,
                 8'hf9, 8'h7d, 8'hc0, 8'ha8, 8'h00, 8'h01, 8'hc0, 8'ha8, 8'h00, 8'h02};

        #12;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("tready_after_reset", in_ready, 1);

        check("model_good", hdr_ok(good), 1);
        run_pkt("good", good, 1'b0);
        check("good_rx_count", rx_count, 8);
        check("good_src_lit", src_ip, 32'hc0a80001);
        check("good_dst_lit", dst_ip, 32'hc0a80002);
        check("good_proto_lit", proto, 8'h11);
        check("good_tlen_lit", tlen, 16'h001c);

        h = '{8'h46, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h11,
              8'hf4, 8'h73, 8'hc0, 8'ha8, 8'h00, 8'h01, 8'hc0, 8'ha8, 8'h00, 8'h02,
              8'h01, 8'h02, 8'h03, 8'h04};
        check("model_ihl6", hdr_ok(h), 1);
        run_pkt("ihl6", h, 1'b0);
        check("ihl6_rx_count", rx_count, 8);
        check("ihl6_tlen_lit", tlen, 16'h0020);

        h = good;
        h[10] = 8'hf8;
        run_pkt("bad_csum", h, 1'b0);
        check("bad_csum_rx_count", rx_count, 0);
        check("bad_csum_tlen_held", tlen, 16'h0020);

        ip_en = 1'b1;
        ip_addr = 32'hc0a80003;
        run_pkt("ip_miss", good, 1'b0);
        check("ip_miss_rx_count", rx_count, 0);
        ip_addr = 32'hc0a80002;
        run_pkt("ip_hit", good, 1'b0);
        ip_en = 1'b0;

        pr_en = 1'b1;
        pr_val = 8'h06;
        run_pkt("proto_miss", good, 1'b0);
        pr_val = 8'h11;
        run_pkt("proto_hit", good, 1'b0);
        pr_en = 1'b0;

        h = good;
        h[0] = 8'h65;
        run_pkt("bad_version", h, 1'b0);

        run_pkt("hdr_gap", good, 1'b1);

        toggle_mode = 1'b1;
        run_pkt("toggle", good, 1'b0);
        check("toggle_rx_count", rx_count, 8);
        toggle_mode = 1'b0;

        // Asynchronous reset mid-payload, then a clean packet.
        s = build_stream(good);
        exp_q.delete();
        rx_count = 0;
        for (int i = 1; i <= 8; i++) exp_q.push_back(8'(i));
        for (int i = 0; i < s.size(); i++) begin
            send_byte(s[i]);
            if (rx_count >= 3) break;
        end
        check("pre_reset_rx", rx_count, 3);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        exp_src = 0; exp_dst = 0; exp_proto = 0; exp_tlen = 0;
        #13;
        rst_n = 1'b1;
        #1;
        check("tready_after_mid_reset", in_ready, 1);
        @(posedge clk);
        #1;
        run_pkt("after_reset", good, 1'b0);
        check("after_reset_rx_count", rx_count, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
